uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receive path: recovers 8N1-style frames from asynchronous serial input `ser_in` by oversampling with the system clock.
- Delivers each received word on a registered valid/ready output with error flags.
- Companion to the existing transmitter; sits between the pad-level RXD pin and the uart2ahb command parser.

Parameters:
- DATA_WIDTH, 8, data bits per frame, LSB first, no parity.
- CLKS_PER_BIT, 16, clk cycles per bit period; legal range >= 4; bit-period counter width is clog2(CLKS_PER_BIT).
- SYNC_STAGES, 2, synchronizer flops on ser_in; legal range >= 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- ser_in  in  1  serial line; asynchronous to clk; idles high.
- rx_data  out  DATA_WIDTH  received word; stable while rx_valid=1.
- rx_valid  out  1  word available; held until accepted.
- rx_ready  in  1  consumer accepts; transfer completes when rx_valid&rx_ready at a clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a good frame completed while the holding register was full; the new word is dropped.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - Synchronizer flops and edge-history flop = 1; state = IDLE; counters = 0.
  - rx_data = 0; rx_valid, frame_err, overrun, busy = 0.
  - Reset mid-frame abandons the frame; no flag is raised.
- Input path:
  - ser_in passes through SYNC_STAGES flops; the result is s_rx.
  - One extra flop holds s_prev for falling-edge detection.
- States:
  - IDLE: on s_prev=1 and s_rx=0, clear the bit counter and go to START. A line held low (break) does not retrigger, because a new start needs a fresh 1->0 edge.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit), then sample s_rx. If 1, it is a false start: return to IDLE with no flags. If 0, clear the counter, clear the bit index, go to DATA.
  - DATA: sample s_rx when the counter reaches CLKS_PER_BIT-1 and shift it into the MSB of the shift register (right-shift, so bit 0 is received first). Increment the bit index. After DATA_WIDTH samples, go to STOP.
  - STOP: sample s_rx at counter CLKS_PER_BIT-1, then always return to IDLE on the next edge.
    - Sample = 1: frame good.
    - Sample = 0: frame_err pulses for exactly 1 cycle; data is discarded; rx_valid is unaffected.
- Output register (good frame, evaluated in the stop-sample cycle):
  - rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data; rx_valid=1 on the next edge; no overrun.
  - rx_valid=1 with rx_ready=0: rx_data is unchanged; overrun pulses for 1 cycle.
  - Acceptance with no new frame: rx_valid=0 next edge; rx_data holds its last value.
- Latency: rx_valid rises 1 clk after the stop-sample edge. From the falling edge on ser_in this is SYNC_STAGES + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 cycles, with +/-1 cycle jitter from edge alignment.
- Timing tolerance: mid-bit sampling tolerates about +/-4% baud mismatch at CLKS_PER_BIT=16.
- busy deasserts in the same cycle the state returns to IDLE. Back-to-back frames with no idle gap are received, because the stop-bit high followed by the next start low provides the edge.
- rx_ready is ignored while rx_valid=0.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - default CLKS_PER_BIT and DATA_WIDTH shared with uart_tx.
- One sub-module, sync_bit: a parameterized SYNC_STAGES flop chain with reset value 1. It is reusable for other async inputs.
- Everything else (FSM, bit counter, shift register, output holding register) stays in uart_rx.

Test Plan (CLKS_PER_BIT=16, DATA_WIDTH=8):
- Good frame 0xA5, rx_ready tied 1 -> rx_valid pulses 1 cycle with rx_data=0xA5; frame_err=0; overrun=0; busy high for about 152 cycles.
- Glitch: ser_in low for 5 cycles, then high -> false start; back to IDLE; no rx_valid, no flags.
- Frame 0x3C with stop bit driven 0 -> frame_err one-cycle pulse; rx_valid stays 0. Line then held low 40 cycles, then high: no new frame starts until a real start edge.
- rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data=0x11 held, overrun pulses once at the end of 0x22. Then assert rx_ready -> rx_valid=0.
- rx_ready pulsed in the exact stop-sample cycle of the second frame 0x55 (first 0xAA pending) -> rx_data=0x55, rx_valid stays 1, no overrun.
- Assert rst at bit 4 of frame 0xFF, release, send 0x81 -> only 0x81 is delivered; no flags; all outputs 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and default frame geometry
// used by both uart_rx and uart_tx.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } rx_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 16;
   localparam int DEFAULT_DATA_WIDTH   = 8;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous input; resets to 1 so an
// idle-high line produces no spurious edge when reset releases.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= '1;
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1 frame recovery from ser_in, with a one-word
// valid/ready holding register plus frame-error and overrun pulses.
//
// state | meaning
// IDLE  | waiting for a fresh 1->0 edge on the synchronized line
// START | counting to mid start bit; a high sample there is a false start
// DATA  | sampling DATA_WIDTH bits at mid-bit, LSB first
// STOP  | sampling the stop bit and updating the output register
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ser_in,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  frame_err,
   output logic                  overrun,
   output logic                  busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_WIDTH);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   logic                  s_rx;
   logic                  s_prev;
   rx_state_t             state;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] shift;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (ser_in),
      .q   (s_rx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) s_prev <= 1'b1;
      else     s_prev <= s_rx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         unique case (state)
            IDLE: begin
               if (s_prev && !s_rx) begin
                  cnt   <= '0;
                  state <= START;
                  busy  <= 1'b1;
               end
            end

            START: begin
               if (cnt == CNT_HALF) begin
                  if (s_rx) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     cnt   <= '0;
                     idx   <= '0;
                     state <= DATA;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (cnt == CNT_FULL) begin
                  cnt   <= '0;
                  shift <= {s_rx, shift[DATA_WIDTH-1:1]};
                  idx   <= idx + 1'b1;
                  if (idx == IDX_LAST)
                     state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            STOP: begin
               if (cnt == CNT_FULL) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (!s_rx) begin
                     frame_err <= 1'b1;
                  end else if (!rx_valid || rx_ready) begin
                     // A same-cycle accept frees the register for the new word.
                     rx_data  <= shift;
                     rx_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16, DATA_WIDTH=8; each task
// drives one scenario and checks against hand-computed expectations.
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int DW  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ser_in = 1'b1;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready = 1'b0;
   logic          frame_err;
   logic          overrun;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   int valid_cyc = 0;
   int acc_cnt   = 0;
   int fe_cnt    = 0;
   int ov_cnt    = 0;
   int busy_cnt  = 0;
   logic [DW-1:0] acc_data = '0;

   uart_rx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .ser_in    (ser_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) valid_cyc++;
         if (rx_valid && rx_ready) begin
            acc_cnt++;
            acc_data = rx_data;
         end
         if (frame_err) fe_cnt++;
         if (overrun)   ov_cnt++;
         if (busy)      busy_cnt++;
      end
   end

   // Caller must be sitting right on a posedge; returns on the edge that ends
   // the stop bit, so consecutive calls produce frames with no idle gap.
   task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit);
      #1 ser_in = 1'b0;
      for (int i = 0; i < DW; i++) begin
         repeat (CPB) @(posedge clk);
         #1 ser_in = d[i];
      end
      repeat (CPB) @(posedge clk);
      #1 ser_in = stop_bit;
      repeat (CPB) @(posedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (rx_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 ||
          overrun !== 1'b0 || rx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b busy=%b fe=%b ov=%b data=%h, want all 0",
                  rx_valid, busy, frame_err, overrun, rx_data);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_good_frame();
      int v0, a0, f0, o0, b0;
      rx_ready = 1'b1;
      v0 = valid_cyc; a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt; b0 = busy_cnt;
      send_frame(8'hA5, 1'b1);
      repeat (20) @(posedge clk);
      n_tests++;
      if (valid_cyc - v0 != 1 || acc_cnt - a0 != 1) begin
         n_fail++;
         $display("FAIL good_valid_pulse: valid cycles=%0d accepts=%0d, want 1 and 1",
                  valid_cyc - v0, acc_cnt - a0);
      end
      n_tests++;
      if (acc_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL good_data: got %h, want a5", acc_data);
      end
      n_tests++;
      if (fe_cnt - f0 != 0 || ov_cnt - o0 != 0) begin
         n_fail++;
         $display("FAIL good_flags: fe=%0d ov=%0d, want 0 0", fe_cnt - f0, ov_cnt - o0);
      end
      n_tests++;
      if (busy_cnt - b0 != 152) begin
         n_fail++;
         $display("FAIL good_busy_len: got %0d cycles, want 152", busy_cnt - b0);
      end
   endtask

   task automatic test_glitch();
      int v0, f0, o0, b0;
      v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt; b0 = busy_cnt;
      #1 ser_in = 1'b0;
      repeat (5) @(posedge clk);
      #1 ser_in = 1'b1;
      repeat (30) @(posedge clk);
      n_tests++;
      if (valid_cyc - v0 != 0 || fe_cnt - f0 != 0 || ov_cnt - o0 != 0) begin
         n_fail++;
         $display("FAIL glitch_no_output: valid=%0d fe=%0d ov=%0d, want 0 0 0",
                  valid_cyc - v0, fe_cnt - f0, ov_cnt - o0);
      end
      n_tests++;
      if (busy_cnt - b0 != 8) begin
         n_fail++;
         $display("FAIL glitch_busy_len: got %0d cycles, want 8", busy_cnt - b0);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_idle: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_frame_error();
      int v0, f0, b0;
      v0 = valid_cyc; f0 = fe_cnt;
      send_frame(8'h3C, 1'b0);
      b0 = busy_cnt;
      repeat (40) @(posedge clk);
      #1 ser_in = 1'b1;
      repeat (40) @(posedge clk);
      n_tests++;
      if (fe_cnt - f0 != 1) begin
         n_fail++;
         $display("FAIL ferr_pulse: frame_err cycles=%0d, want 1", fe_cnt - f0);
      end
      n_tests++;
      if (valid_cyc - v0 != 0 || rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ferr_no_valid: valid cycles=%0d rx_valid=%b, want 0 0",
                  valid_cyc - v0, rx_valid);
      end
      n_tests++;
      if (busy_cnt - b0 != 0) begin
         n_fail++;
         $display("FAIL break_no_restart: busy cycles=%0d, want 0", busy_cnt - b0);
      end
   endtask

   task automatic test_overrun();
      int o0, f0;
      rx_ready = 1'b0;
      o0 = ov_cnt; f0 = fe_cnt;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
         n_fail++;
         $display("FAIL ovr_hold: valid=%b data=%h, want 1 11", rx_valid, rx_data);
      end
      n_tests++;
      if (ov_cnt - o0 != 1 || fe_cnt - f0 != 0) begin
         n_fail++;
         $display("FAIL ovr_pulse: overrun=%0d fe=%0d, want 1 0", ov_cnt - o0, fe_cnt - f0);
      end
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      n_tests++;
      if (rx_valid !== 1'b0 || rx_data !== 8'h11) begin
         n_fail++;
         $display("FAIL ovr_accept: valid=%b data=%h, want 0 11", rx_valid, rx_data);
      end
      @(posedge clk);
   endtask

   task automatic test_accept_at_stop();
      int o0;
      rx_ready = 1'b0;
      o0 = ov_cnt;
      send_frame(8'hAA, 1'b1);
      repeat (5) @(posedge clk);
      fork
         send_frame(8'h55, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      repeat (5) @(posedge clk);
      #1;
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
         n_fail++;
         $display("FAIL stop_accept_data: valid=%b data=%h, want 1 55", rx_valid, rx_data);
      end
      n_tests++;
      if (ov_cnt - o0 != 0) begin
         n_fail++;
         $display("FAIL stop_accept_ovr: overrun=%0d, want 0", ov_cnt - o0);
      end
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      n_tests++;
      if (rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_accept_drain: valid=%b, want 0", rx_valid);
      end
      @(posedge clk);
   endtask

   task automatic test_reset_mid_frame();
      int v0, a0, f0, o0;
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (CPB * 5 + 8) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            n_tests++;
            if (rx_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 ||
                overrun !== 1'b0 || rx_data !== 8'h00) begin
               n_fail++;
               $display("FAIL midreset_outputs: valid=%b busy=%b fe=%b ov=%b data=%h, want all 0",
                        rx_valid, busy, frame_err, overrun, rx_data);
            end
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      repeat (10) @(posedge clk);
      rx_ready = 1'b1;
      v0 = valid_cyc; a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
      send_frame(8'h81, 1'b1);
      repeat (20) @(posedge clk);
      n_tests++;
      if (acc_cnt - a0 != 1 || valid_cyc - v0 != 1) begin
         n_fail++;
         $display("FAIL midreset_count: accepts=%0d valid cycles=%0d, want 1 1",
                  acc_cnt - a0, valid_cyc - v0);
      end
      n_tests++;
      if (acc_data !== 8'h81) begin
         n_fail++;
         $display("FAIL midreset_data: got %h, want 81", acc_data);
      end
      n_tests++;
      if (fe_cnt - f0 != 0 || ov_cnt - o0 != 0) begin
         n_fail++;
         $display("FAIL midreset_flags: fe=%0d ov=%0d, want 0 0", fe_cnt - f0, ov_cnt - o0);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_accept_at_stop();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
